oled_i2c_writer: RTL and testbench
==================================

Name: oled_i2c_writer

Overview:
- I2C master write engine that consumes 24-bit command frames {slave addr, control byte, data byte} from the OLED init/data sequencers and serialises them onto the OLED's I2C bus.
- Issues START, three bytes MSB-first with an ACK slot after each, then STOP.
- Pulses a one-cycle done strobe so the upstream sequencer can advance its index and present the next frame.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- I2C_FREQ, 400_000, SCL frequency in Hz.
- QTR, derived localparam, CLK_FREQ/(4*I2C_FREQ) with integer floor (31 at defaults). Clock cycles per quarter SCL period. Must be >= 1.

Ports:
- clk_50m  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  request. Level-sampled, and only while idle.
- i_data  in  24  frame: [23:16] slave address byte incl. R/W=0, [15:8] control byte, [7:0] payload.
- o_busy  out  1  high from accept through the done cycle.
- o_write_done  out  1  one-cycle pulse when STOP completes.
- o_ack_err  out  1  sticky NACK flag. Cleared on next accept.
- o_scl  out  1  SCL, push-pull. 1 = high.
- o_sda_oe  out  1  SDA open-drain enable. 1 = pull low, 0 = release.
- i_sda  in  1  sampled SDA line.

Behaviour:
- Reset (rst=1 at clk edge), all values registered:
  - o_scl=1, o_sda_oe=0, o_busy=0, o_write_done=0, o_ack_err=0, FSM=IDLE, counters=0.
  - Reset mid-transaction releases both lines on the next edge. No STOP is generated.
- FSM states: IDLE, START, BIT, ACK, STOP, DONE.
- Timing: each slot (START, each data bit, each ACK, STOP) = 4 quarters q0..q3, each QTR cycles long. Quarter and bit counters advance only on the quarter-counter terminal count.
- IDLE:
  - If i_start=1: latch i_data into shift register, clear o_ack_err, set o_busy, go to START.
  - i_data and i_start are ignored in all other states.
- START slot:
  - q0,q1: SCL=1, SDA released.
  - q2: SCL=1, SDA low.
  - q3: SCL=0, SDA low.
- BIT slot (8 per byte, MSB first):
  - q0: SCL=0, SDA driven from current bit (bit=0 → oe=1, bit=1 → oe=0).
  - q1: SCL=0.
  - q2,q3: SCL=1.
  - After bit 0 of a byte, go to ACK.
- ACK slot:
  - SDA released throughout. SCL pattern same as BIT.
  - i_sda sampled on the last clock of q2.
  - Sample 0 (ACK): next byte, or STOP after the third byte.
  - Sample 1 (NACK): o_ack_err=1 and go directly to STOP; remaining bytes are skipped.
- STOP slot:
  - q0: SCL=0, SDA low.
  - q1: SCL=1, SDA low.
  - q2,q3: SCL=1, SDA released.
- DONE: one cycle with o_write_done=1, o_busy=1. Next state is IDLE.
- Latency, full frame: 29 slots × 4 × QTR cycles from the accept edge to the DONE cycle (3596 at defaults).
- Latency, NACK: after byte k (k=1..3), (1 + 9k + 1) × 4 × QTR cycles.
- Back-to-back: with i_start held high, the next accept occurs in the first IDLE cycle after DONE, i.e. 2 cycles after the done pulse edge. The upstream index update on the done edge is visible by then.
- o_ack_err holds its value through IDLE until the next accept.

Test Plan:
- Reset: assert rst 3 cycles mid-idle → o_scl=1, o_sda_oe=0, o_busy=0, o_write_done=0, o_ack_err=0.
- Full write, default params, slave always ACKs, i_data=24'h7800AE:
  - SDA bit sequence 01111000 A 00000000 A 10101110 A, bracketed by a correct START and STOP.
  - o_write_done pulses once, 3596 cycles after accept.
  - o_ack_err=0.
- NACK on address byte (i_sda=1 in first ACK slot):
  - o_ack_err=1, no further data bits, STOP follows.
  - o_write_done 11×4×31=1364 cycles after accept.
  - o_ack_err remains 1 until next accept.
- Back-to-back, override CLK_FREQ=400/I2C_FREQ=100 (QTR=1), i_start held high, i_data changed on done edge:
  - Second frame accepted 2 cycles after the done pulse.
  - Second frame serialises the new data.
- Mid-transaction disturbance:
  - Toggle i_start and change i_data during byte 2 → transmitted bits unchanged.
  - Then assert rst during byte 2 → next edge gives o_scl=1, o_sda_oe=0, o_busy=0, with no o_write_done.

Source files
------------

// File: rtl/oled_i2c_writer.sv
// ============================================================================
// Module      : oled_i2c_writer
// Description : I2C master write engine. Sends a 3-byte frame
//               {slave addr, control, data} as START, bytes+ACK, STOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_i2c_writer #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 400_000
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        i_start,
    input  logic [23:0] i_data,
    output logic        o_busy,
    output logic        o_write_done,
    output logic        o_ack_err,
    output logic        o_scl,
    output logic        o_sda_oe,
    input  logic        i_sda
);

    localparam int QTR  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int c_QW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [c_QW-1:0] c_QTR_LAST = c_QW'(QTR - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_BIT   = 3'd2;
    localparam logic [2:0] c_ST_ACK   = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]      r_state,   w_state;
    logic [c_QW-1:0] r_qcnt,    w_qcnt;
    logic [1:0]      r_quarter, w_quarter;
    logic [2:0]      r_bit,     w_bit;
    logic [1:0]      r_byte,    w_byte;
    logic [23:0]     r_shift,   w_shift;
    logic            r_nack,    w_nack;
    logic            r_ack_err, w_ack_err;
    logic            r_scl,     w_scl;
    logic            r_sda_oe,  w_sda_oe;
    logic            r_busy;
    logic            r_done;
    logic            w_tc;
    logic            w_slot_end;

    always_comb begin
        w_state    = r_state;
        w_qcnt     = r_qcnt;
        w_quarter  = r_quarter;
        w_bit      = r_bit;
        w_byte     = r_byte;
        w_shift    = r_shift;
        w_nack     = r_nack;
        w_ack_err  = r_ack_err;
        w_tc       = (r_qcnt == c_QTR_LAST);
        w_slot_end = w_tc && (r_quarter == 2'd3);

        case (r_state)
            c_ST_IDLE: begin
                if (i_start) begin
                    w_state   = c_ST_START;
                    w_qcnt    = '0;
                    w_quarter = 2'd0;
                    w_bit     = 3'd0;
                    w_byte    = 2'd0;
                    w_shift   = i_data;
                    w_nack    = 1'b0;
                    w_ack_err = 1'b0;
                end
            end
            c_ST_DONE: begin
                w_state   = c_ST_IDLE;
                w_qcnt    = '0;
                w_quarter = 2'd0;
                w_bit     = 3'd0;
                w_byte    = 2'd0;
            end
            default: begin
                w_qcnt = w_tc ? '0 : r_qcnt + 1'b1;
                if (w_tc) begin
                    w_quarter = r_quarter + 2'd1;
                end
                // Slave answer is taken on the final clock of the SCL-high first half
                if ((r_state == c_ST_ACK) && w_tc && (r_quarter == 2'd2)) begin
                    w_nack = i_sda;
                    if (i_sda) begin
                        w_ack_err = 1'b1;
                    end
                end
                if (w_slot_end) begin
                    case (r_state)
                        c_ST_START: w_state = c_ST_BIT;
                        c_ST_BIT: begin
                            w_shift = {r_shift[22:0], 1'b0};
                            w_bit   = r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                w_state = c_ST_ACK;
                            end
                        end
                        c_ST_ACK: begin
                            if (r_nack || (r_byte == 2'd2)) begin
                                w_state = c_ST_STOP;
                            end else begin
                                w_state = c_ST_BIT;
                                w_byte  = r_byte + 2'd1;
                            end
                        end
                        c_ST_STOP: w_state = c_ST_DONE;
                        default:   w_state = r_state;
                    endcase
                end
            end
        endcase

        // Line levels are derived from the next state so they register in step with it
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
        case (w_state)
            c_ST_START: begin
                w_scl    = (w_quarter != 2'd3);
                w_sda_oe = w_quarter[1];
            end
            c_ST_BIT: begin
                w_scl    = w_quarter[1];
                w_sda_oe = ~w_shift[23];
            end
            c_ST_ACK: begin
                w_scl    = w_quarter[1];
                w_sda_oe = 1'b0;
            end
            c_ST_STOP: begin
                w_scl    = (w_quarter != 2'd0);
                w_sda_oe = ~w_quarter[1];
            end
            default: begin
                w_scl    = 1'b1;
                w_sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_qcnt    <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_shift   <= 24'd0;
            r_nack    <= 1'b0;
            r_ack_err <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_qcnt    <= w_qcnt;
            r_quarter <= w_quarter;
            r_bit     <= w_bit;
            r_byte    <= w_byte;
            r_shift   <= w_shift;
            r_nack    <= w_nack;
            r_ack_err <= w_ack_err;
            r_scl     <= w_scl;
            r_sda_oe  <= w_sda_oe;
            r_busy    <= (w_state != c_ST_IDLE);
            r_done    <= (w_state == c_ST_DONE);
        end
    end

    assign o_busy       = r_busy;
    assign o_write_done = r_done;
    assign o_ack_err    = r_ack_err;
    assign o_scl        = r_scl;
    assign o_sda_oe     = r_sda_oe;

endmodule

`default_nettype wire

// File: tb/tb_oled_i2c_writer.sv
// ============================================================================
// Module      : tb_oled_i2c_writer
// Description : Directed self-checking bench for oled_i2c_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_i2c_writer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        d_rst = 1'b1, d_start = 1'b0, d_sda = 1'b0;
    logic [23:0] d_data = 24'd0;
    logic        d_busy, d_done, d_err, d_scl, d_oe;

    logic        f_rst = 1'b1, f_start = 1'b0, f_sda = 1'b0;
    logic [23:0] f_data = 24'd0;
    logic        f_busy, f_done, f_err, f_scl, f_oe;

    int n_cmp = 0;
    int n_err = 0;

    oled_i2c_writer u_dut_def (
        .clk_50m(clk), .rst(d_rst), .i_start(d_start), .i_data(d_data),
        .o_busy(d_busy), .o_write_done(d_done), .o_ack_err(d_err),
        .o_scl(d_scl), .o_sda_oe(d_oe), .i_sda(d_sda)
    );

    oled_i2c_writer #(.CLK_FREQ(400), .I2C_FREQ(100)) u_dut_fast (
        .clk_50m(clk), .rst(f_rst), .i_start(f_start), .i_data(f_data),
        .o_busy(f_busy), .o_write_done(f_done), .o_ack_err(f_err),
        .o_scl(f_scl), .o_sda_oe(f_oe), .i_sda(f_sda)
    );

    // Bus observers: SDA level at each SCL rise, plus START/STOP conditions
    logic [63:0] d_bits = '0, f_bits = '0;
    int d_rises = 0, d_starts = 0, d_stops = 0;
    int f_rises = 0, f_starts = 0, f_stops = 0;
    logic d_scl_q = 1'b1, d_oe_q = 1'b0, f_scl_q = 1'b1, f_oe_q = 1'b0;

    always @(negedge clk) begin
        if (d_scl && !d_scl_q) begin
            d_bits  <= {d_bits[62:0], ~d_oe};
            d_rises <= d_rises + 1;
        end
        if (d_scl && d_scl_q && d_oe && !d_oe_q) d_starts <= d_starts + 1;
        if (d_scl && d_scl_q && !d_oe && d_oe_q) d_stops <= d_stops + 1;
        d_scl_q <= d_scl;
        d_oe_q  <= d_oe;
    end

    always @(negedge clk) begin
        if (f_scl && !f_scl_q) begin
            f_bits  <= {f_bits[62:0], ~f_oe};
            f_rises <= f_rises + 1;
        end
        if (f_scl && f_scl_q && f_oe && !f_oe_q) f_starts <= f_starts + 1;
        if (f_scl && f_scl_q && !f_oe && f_oe_q) f_stops <= f_stops + 1;
        f_scl_q <= f_scl;
        f_oe_q  <= f_oe;
    end

    // Last 28 SCL rises of a full frame: 24 data, 3 ACK slots, 1 STOP rise
    function automatic logic [23:0] frame_data(input logic [63:0] b);
        return {b[27:20], b[18:11], b[9:2]};
    endfunction

    task automatic test_reset();
        d_start = 1'b0;
        @(negedge clk);
        d_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (d_scl !== 1'b1)  begin n_err++; $display("FAIL reset_scl: got %b want 1", d_scl); end
        n_cmp++; if (d_oe !== 1'b0)   begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", d_oe); end
        n_cmp++; if (d_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", d_busy); end
        n_cmp++; if (d_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", d_done); end
        n_cmp++; if (d_err !== 1'b0)  begin n_err++; $display("FAIL reset_ack_err: got %b want 0", d_err); end
        @(negedge clk);
        d_rst = 1'b0;
    endtask

    task automatic test_nack();
        int r0, s0, p0, cyc;
        bit seen;
        @(negedge clk);
        r0 = d_rises; s0 = d_starts; p0 = d_stops;
        d_sda = 1'b1; d_data = 24'h7800AE; d_start = 1'b1;
        @(posedge clk); #1; d_start = 1'b0;
        n_cmp++; if (d_busy !== 1'b1) begin n_err++; $display("FAIL nack_busy_accept: got %b want 1", d_busy); end
        cyc = 0; seen = 0;
        while (!seen && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (d_done) seen = 1;
        end
        n_cmp++; if (!seen || cyc != 1364) begin n_err++; $display("FAIL nack_latency: got %0d (seen=%0b) want 1364", cyc, seen); end
        n_cmp++; if (d_err !== 1'b1) begin n_err++; $display("FAIL nack_ack_err: got %b want 1", d_err); end
        @(negedge clk); #1;
        n_cmp++; if (d_rises - r0 != 10) begin n_err++; $display("FAIL nack_scl_rises: got %0d want 10", d_rises - r0); end
        n_cmp++; if (d_bits[9:2] !== 8'h78) begin n_err++; $display("FAIL nack_addr_bits: got %h want 78", d_bits[9:2]); end
        n_cmp++; if (d_starts - s0 != 1) begin n_err++; $display("FAIL nack_start: got %0d want 1", d_starts - s0); end
        n_cmp++; if (d_stops - p0 != 1) begin n_err++; $display("FAIL nack_stop: got %0d want 1", d_stops - p0); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (d_err !== 1'b1) begin n_err++; $display("FAIL nack_err_sticky: got %b want 1", d_err); end
        n_cmp++; if (d_busy !== 1'b0) begin n_err++; $display("FAIL nack_idle_busy: got %b want 0", d_busy); end
    endtask

    task automatic test_full_write();
        int r0, s0, p0, cyc;
        bit seen;
        @(negedge clk);
        r0 = d_rises; s0 = d_starts; p0 = d_stops;
        d_sda = 1'b0; d_data = 24'h7800AE; d_start = 1'b1;
        @(posedge clk); #1; d_start = 1'b0;
        n_cmp++; if (d_err !== 1'b0) begin n_err++; $display("FAIL full_err_cleared: got %b want 0", d_err); end
        cyc = 0; seen = 0;
        while (!seen && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (d_done) seen = 1;
        end
        n_cmp++; if (!seen || cyc != 3596) begin n_err++; $display("FAIL full_latency: got %0d (seen=%0b) want 3596", cyc, seen); end
        n_cmp++; if (d_busy !== 1'b1) begin n_err++; $display("FAIL full_busy_done: got %b want 1", d_busy); end
        @(negedge clk); #1;
        n_cmp++; if (d_rises - r0 != 28) begin n_err++; $display("FAIL full_scl_rises: got %0d want 28", d_rises - r0); end
        n_cmp++; if (frame_data(d_bits) !== 24'h7800AE) begin n_err++; $display("FAIL full_data: got %h want 7800ae", frame_data(d_bits)); end
        n_cmp++; if ({d_bits[19], d_bits[10], d_bits[1]} !== 3'b111) begin n_err++; $display("FAIL full_ack_release: got %b want 111", {d_bits[19], d_bits[10], d_bits[1]}); end
        n_cmp++; if (d_starts - s0 != 1) begin n_err++; $display("FAIL full_start: got %0d want 1", d_starts - s0); end
        n_cmp++; if (d_stops - p0 != 1) begin n_err++; $display("FAIL full_stop: got %0d want 1", d_stops - p0); end
        @(posedge clk); #1;
        n_cmp++; if (d_done !== 1'b0) begin n_err++; $display("FAIL full_done_width: got %b want 0", d_done); end
        n_cmp++; if (d_busy !== 1'b0) begin n_err++; $display("FAIL full_busy_after: got %b want 0", d_busy); end
        n_cmp++; if (d_err !== 1'b0) begin n_err++; $display("FAIL full_ack_err: got %b want 0", d_err); end
    endtask

    task automatic test_back_to_back();
        int r0, r1, cyc;
        bit seen;
        @(negedge clk);
        f_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        f_rst = 1'b0;
        r0 = f_rises;
        f_sda = 1'b0; f_data = 24'h7840A5; f_start = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (f_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept1: got %b want 1", f_busy); end
        cyc = 0; seen = 0;
        while (!seen && cyc < 500) begin
            @(posedge clk); #1; cyc++;
            if (f_done) seen = 1;
        end
        f_data = 24'h78003C;
        n_cmp++; if (!seen || cyc != 116) begin n_err++; $display("FAIL b2b_latency1: got %0d (seen=%0b) want 116", cyc, seen); end
        n_cmp++; if (frame_data(f_bits) !== 24'h7840A5) begin n_err++; $display("FAIL b2b_data1: got %h want 7840a5", frame_data(f_bits)); end
        r1 = f_rises;
        n_cmp++; if (r1 - r0 != 28) begin n_err++; $display("FAIL b2b_rises1: got %0d want 28", r1 - r0); end
        @(posedge clk); #1;
        n_cmp++; if (f_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: got %b want 0", f_busy); end
        @(posedge clk); #1;
        n_cmp++; if (f_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept2: got %b want 1", f_busy); end
        f_start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 500) begin
            @(posedge clk); #1; cyc++;
            if (f_done) seen = 1;
        end
        n_cmp++; if (!seen || cyc != 116) begin n_err++; $display("FAIL b2b_latency2: got %0d (seen=%0b) want 116", cyc, seen); end
        n_cmp++; if (frame_data(f_bits) !== 24'h78003C) begin n_err++; $display("FAIL b2b_data2: got %h want 78003c", frame_data(f_bits)); end
        n_cmp++; if (f_rises - r1 != 28) begin n_err++; $display("FAIL b2b_rises2: got %0d want 28", f_rises - r1); end
    endtask

    task automatic test_disturb();
        int r0, cyc, dones;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        r0 = f_rises;
        f_data = 24'h3C5A96; f_start = 1'b1;
        @(posedge clk); #1; f_start = 1'b0;
        repeat (50) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            f_start = ~f_start;
            f_data  = 24'($urandom);
        end
        f_start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 500) begin
            @(posedge clk); #1; cyc++;
            if (f_done) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL dist_done: got timeout want done pulse"); end
        n_cmp++; if (frame_data(f_bits) !== 24'h3C5A96) begin n_err++; $display("FAIL dist_data: got %h want 3c5a96", frame_data(f_bits)); end
        n_cmp++; if (f_rises - r0 != 28) begin n_err++; $display("FAIL dist_rises: got %0d want 28", f_rises - r0); end

        repeat (3) @(posedge clk);
        @(negedge clk);
        f_data = 24'h3C5A96; f_start = 1'b1;
        @(posedge clk); #1; f_start = 1'b0;
        repeat (55) @(posedge clk);
        @(negedge clk);
        f_rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (f_scl !== 1'b1)  begin n_err++; $display("FAIL rst_mid_scl: got %b want 1", f_scl); end
        n_cmp++; if (f_oe !== 1'b0)   begin n_err++; $display("FAIL rst_mid_sda_oe: got %b want 0", f_oe); end
        n_cmp++; if (f_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", f_busy); end
        n_cmp++; if (f_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", f_done); end
        @(negedge clk);
        f_rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (f_done || f_busy) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", dones); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_nack();
        test_full_write();
        test_back_to_back();
        test_disturb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
